// File: rtl/chunked_adder_pkg.sv
// Shared types and default sizing for the chunked (bit-serial-by-chunk) adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package chunked_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_rca.sv
// Purpose: W-bit combinational ripple-carry adder used for one chunk per clock.
// Latency: purely combinational, 0 cycles. Backpressure: none (no state).
// Ports: a, b, cin -> s (W-bit sum), cout (carry out of bit W-1), c_msb (carry into bit W-1).
module chunk_rca
    import chunked_adder_pkg::*;
#(
    parameter int W = DEFAULT_CHUNK
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[W];
    // Carry into the top bit; XOR with cout gives signed overflow.
    assign c_msb = c[W-1];

endmodule

// File: rtl/chunked_adder.sv
// Purpose: WIDTH-bit add/subtract computed CHUNK bits per cycle through one chunk_rca.
// Latency: N = WIDTH/CHUNK cycles from acceptance to out_valid; one result per N+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid & out_ready.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + a, b, cin, sub command;
//        out_valid/out_ready + s, cout result; ovf only when CHUNKED_ADDER_OVF_EN is defined.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef CHUNKED_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    // Divisor guarded so an illegal CHUNK of 0 does not itself break the check.
    localparam bit CFG_OK = (CHUNK > 0) && (WIDTH > 0) &&
                            ((WIDTH % ((CHUNK > 0) ? CHUNK : 1)) == 0);

    if (!CFG_OK) begin : g_bad_cfg
        $error("chunked_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    localparam int N    = (CFG_OK) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  b_q,     b_d;     // already inverted in sub mode
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  s_q,     s_d;
    logic              cout_q,  cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
    logic              ovf_q,   ovf_d;
`endif

    logic [CHUNK-1:0]  rca_a, rca_b, rca_s;
    logic              rca_cout;
`ifdef CHUNKED_ADDER_OVF_EN
    logic              rca_c_msb;
`else
    logic              unused_rca_c_msb;
`endif

    assign rca_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign rca_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

    chunk_rca #(
        .W (CHUNK)
    ) u_rca (
        .a     (rca_a),
        .b     (rca_b),
        .cin   (carry_q),
        .s     (rca_s),
        .cout  (rca_cout),
`ifdef CHUNKED_ADDER_OVF_EN
        .c_msb (rca_c_msb)
`else
        .c_msb (unused_rca_c_msb)
`endif
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction as A + ~B + 1; cin is irrelevant here.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(idx_q) * CHUNK +: CHUNK] = rca_s;
                carry_d = rca_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = rca_cout;
`ifdef CHUNKED_ADDER_OVF_EN
                    ovf_d   = rca_c_msb ^ rca_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, total operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands/command valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a command.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in (add mode only).
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port s  output  WIDTH  sum/difference.
REQ-014 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-015 SHALL require WIDTH to be a non-zero multiple of CHUNK; N = WIDTH/CHUNK; an illegal combination SHALL stop elaboration.
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 SHALL assert in_ready only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-018 On acceptance SHALL latch a, b, cin and sub, clear the chunk index, and go IDLE->RUN.
REQ-019 In sub mode SHALL use ~b as operand B and force the initial carry to 1, ignoring cin.
REQ-020 Each RUN edge SHALL add chunk[idx] of A and B with the running carry, write the CHUNK-bit sum into s[idx*CHUNK +: CHUNK], register the carry, and increment idx.
REQ-021 On the RUN edge with idx == N-1 SHALL go RUN->DONE and load cout with the final carry.
REQ-022 out_valid SHALL be 1 only in DONE; latency from the acceptance edge to out_valid high SHALL be exactly N cycles.
REQ-023 DONE SHALL hold s, cout and out_valid stable until out_valid & out_ready at an edge, then go DONE->IDLE.
REQ-024 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE (no queuing).
REQ-025 The result SHALL equal (A + B + cin) mod 2^WIDTH, or (A - B) mod 2^WIDTH, with cout the true carry (sub mode: cout=1 means no borrow).
REQ-026 A new command SHALL be accepted no earlier than the edge after DONE->IDLE; throughput is one result per N+2 cycles minimum.

Reset
REQ-027 rst_n low at a rising edge SHALL force IDLE, idx=0, s=0, cout=0, out_valid=0, in_ready=1 (after release), discarding any operation in progress.
REQ-028 Reset SHALL take priority over acceptance and over completion at the same edge.

Configuration
REQ-029 With CHUNKED_ADDER_OVF_EN defined SHALL add output ovf (1 bit) = carry into bit WIDTH-1 XOR cout, valid with out_valid, reset 0.
REQ-030 Without CHUNKED_ADDER_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package chunked_adder_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and default WIDTH/CHUNK constants.
REQ-032 The per-cycle CHUNK-bit combinational ripple adder SHALL be a sub-module named chunk_rca (a, b, cin -> s, cout, c_msb).

Verification (WIDTH=8, CHUNK=4 unless noted)
REQ-033 a=0xFF b=0x00 cin=0 sub=0 -> s=0xFF cout=0 exactly 2 cycles after acceptance.
REQ-034 a=0xFF b=0x00 cin=1 sub=0 -> s=0x00 cout=1; with OVF_EN, ovf=0.
REQ-035 a=0x05 b=0x07 sub=1 -> s=0xFE cout=0; a=0x80 b=0x01 sub=1 -> s=0x7F cout=1, ovf=1.
REQ-036 out_ready held low 5 cycles in DONE -> s/cout/out_valid stable, in_ready=0, new in_valid ignored.
REQ-037 rst_n low for 1 cycle in the middle of RUN -> IDLE next cycle, out_valid never asserted, next command computes correctly.
REQ-038 WIDTH=32 CHUNK=8, 1000 random a/b/cin/sub with random out_ready -> all results match the reference model, latency 4 cycles.
